// File: rtl/lvds_rx_pkg.sv
// Shared encodings for the LVDS RX stream arbiter: modes, status FSM states, channel IDs.
package lvds_rx_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_CH0  = 2'b01;
  localparam logic [1:0] MODE_CH1  = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_DROP  = 2'b11
  } state_t;

endpackage

// File: rtl/rx_hold_fifo.sv
// Per-channel first-word-fall-through holding FIFO; write while full is legal when the
// same cycle also reads, flush empties it in one edge.
module rx_hold_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd,
  input  logic              i_flush,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       cnt;

  // Storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge i_clk)
    if (i_wr) mem[wptr] <= i_wdata;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (i_flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      wptr <= wptr + AW'(i_wr);
      rptr <= rptr + AW'(i_rd);
      cnt  <= cnt + (AW+1)'(i_wr) - (AW+1)'(i_rd);
    end
  end

  assign o_full  = (cnt == (AW+1)'(DEPTH));
  assign o_empty = (cnt == '0);
  assign o_head  = mem[rptr];

endmodule

// File: rtl/lvds_rx_stream_arbiter.sv
// Merges two LVDS RX deframer word streams into one shared FIFO write port with
// round-robin arbitration, per-channel holding FIFOs and saturating drop counters.
module lvds_rx_stream_arbiter
  import lvds_rx_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int HOLD_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [1:0]        i_mode,
  input  logic              i_ch0_push,
  input  logic [DATA_W-1:0] i_ch0_data,
  input  logic              i_ch1_push,
  input  logic [DATA_W-1:0] i_ch1_data,
  input  logic              i_fifo_full,
  input  logic              i_stat_clear,
  output logic              o_fifo_push,
  output logic [DATA_W-1:0] o_fifo_data,
  output logic              o_fifo_chan,
  output logic [CNT_W-1:0]  o_drop_cnt0,
  output logic [CNT_W-1:0]  o_drop_cnt1,
  output logic              o_drop_flag,
  output logic [1:0]        o_state
);
  logic [1:0]             en, push, wr, rd, h_full, h_empty, cand, drop;
  logic [1:0][DATA_W-1:0] din, head;
  logic [1:0][CNT_W-1:0]  cnt;
  logic                   last_grant, gnt_vld, gnt_ch;
  state_t                 state, state_nxt;

  assign en   = i_mode;
  assign push = {i_ch1_push, i_ch0_push};
  assign din  = {i_ch1_data, i_ch0_data};
  assign cand = en & ~h_empty;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = CH0;
    if (!i_fifo_full) begin
      unique case (cand)
        2'b01:   begin gnt_vld = 1'b1; gnt_ch = CH0;         end
        2'b10:   begin gnt_vld = 1'b1; gnt_ch = CH1;         end
        2'b11:   begin gnt_vld = 1'b1; gnt_ch = ~last_grant; end
        default: ;
      endcase
    end
    rd = '0;
    if (gnt_vld) rd[gnt_ch] = 1'b1;
  end

  // A full FIFO still accepts a word when it is being popped at the same edge.
  assign drop = push & en & h_full & ~rd;
  assign wr   = push & en & ~drop;

  // Disabled channels are held flushed, which empties them on the enable->disable edge.
  for (genvar g = 0; g < 2; g++) begin : g_ch
    rx_hold_fifo #(.DATA_W(DATA_W), .DEPTH(HOLD_DEPTH)) u_hold (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_wr      (wr[g]),
      .i_wdata   (din[g]),
      .i_rd      (rd[g]),
      .i_flush   (~en[g]),
      .o_full    (h_full[g]),
      .o_empty   (h_empty[g]),
      .o_head    (head[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_fifo_push <= 1'b0;
      o_fifo_data <= '0;
      o_fifo_chan <= CH0;
      last_grant  <= CH1;
    end else begin
      o_fifo_push <= gnt_vld;
      if (gnt_vld) begin
        o_fifo_data <= head[gnt_ch];
        o_fifo_chan <= gnt_ch;
        last_grant  <= gnt_ch;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt         <= '0;
      o_drop_flag <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (i_stat_clear)                cnt[c] <= CNT_W'(drop[c]);
        else if (drop[c] && !(&cnt[c]))  cnt[c] <= cnt[c] + 1'b1;
      end
      o_drop_flag <= (i_stat_clear ? 1'b0 : o_drop_flag) | (|drop);
    end
  end

  assign o_drop_cnt0 = cnt[0];
  assign o_drop_cnt1 = cnt[1];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_OFF;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_RUN;
    if (i_mode == MODE_OFF)           state_nxt = ST_OFF;
    else if (|drop)                   state_nxt = ST_DROP;
    else if (i_fifo_full && (|cand))  state_nxt = ST_STALL;
  end

  assign o_state = state;

endmodule

// File: tb/tb_lvds_rx_stream_arbiter.sv
// Randomized and directed bench for lvds_rx_stream_arbiter against a queue-based model.
module tb_lvds_rx_stream_arbiter;
  localparam int DW = 32, D = 4, CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          i_clk = 1'b0, i_reset_n = 1'b0;
  logic [1:0]    i_mode = 2'b00;
  logic          i_ch0_push = 1'b0, i_ch1_push = 1'b0;
  logic [DW-1:0] i_ch0_data = '0, i_ch1_data = '0;
  logic          i_fifo_full = 1'b0, i_stat_clear = 1'b0;
  logic          o_fifo_push, o_fifo_chan, o_drop_flag;
  logic [DW-1:0] o_fifo_data;
  logic [CW-1:0] o_drop_cnt0, o_drop_cnt1;
  logic [1:0]    o_state;

  lvds_rx_stream_arbiter #(.DATA_W(DW), .HOLD_DEPTH(D), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_mode(i_mode),
    .i_ch0_push(i_ch0_push), .i_ch0_data(i_ch0_data),
    .i_ch1_push(i_ch1_push), .i_ch1_data(i_ch1_data),
    .i_fifo_full(i_fifo_full), .i_stat_clear(i_stat_clear),
    .o_fifo_push(o_fifo_push), .o_fifo_data(o_fifo_data), .o_fifo_chan(o_fifo_chan),
    .o_drop_cnt0(o_drop_cnt0), .o_drop_cnt1(o_drop_cnt1),
    .o_drop_flag(o_drop_flag), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_pass = 0;
  int writes = 0, wr_ch0 = 0, wr_ch1 = 0, first_ch = -1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference model: channel queues plus round-robin memory.
  logic [DW-1:0] q0[$], q1[$];
  int            lastg, mcnt0, mcnt1;
  bit            mflag, mpush, mchan;
  logic [DW-1:0] mdata;
  logic [1:0]    mstate;

  task automatic model_reset();
    q0.delete(); q1.delete();
    lastg = 1; mcnt0 = 0; mcnt1 = 0; mflag = 0;
    mpush = 0; mdata = '0; mchan = 0; mstate = 2'b00;
  endtask

  task automatic model_step();
    bit en0, en1, c0, c1, d0, d1;
    int g;
    en0 = i_mode[0]; en1 = i_mode[1];
    c0 = en0 && q0.size() > 0;
    c1 = en1 && q1.size() > 0;
    g = -1;
    if (!i_fifo_full) begin
      if (c0 && c1)  g = (lastg == 1) ? 0 : 1;
      else if (c0)   g = 0;
      else if (c1)   g = 1;
    end
    d0 = i_ch0_push && en0 && q0.size() == D && g != 0;
    d1 = i_ch1_push && en1 && q1.size() == D && g != 1;
    if (i_mode == 2'b00)                 mstate = 2'b00;
    else if (d0 || d1)                   mstate = 2'b11;
    else if (i_fifo_full && (c0 || c1))  mstate = 2'b10;
    else                                 mstate = 2'b01;
    mpush = (g >= 0);
    if (g == 0) begin mdata = q0.pop_front(); mchan = 0; lastg = 0; end
    if (g == 1) begin mdata = q1.pop_front(); mchan = 1; lastg = 1; end
    if (en0 && i_ch0_push && !d0) q0.push_back(i_ch0_data);
    if (en1 && i_ch1_push && !d1) q1.push_back(i_ch1_data);
    if (!en0) q0.delete();
    if (!en1) q1.delete();
    if (i_stat_clear) begin
      mcnt0 = d0 ? 1 : 0; mcnt1 = d1 ? 1 : 0; mflag = d0 || d1;
    end else begin
      if (d0 && mcnt0 != CMAX) mcnt0++;
      if (d1 && mcnt1 != CMAX) mcnt1++;
      mflag = mflag || d0 || d1;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
    chk("push",  o_fifo_push, mpush);
    chk("data",  o_fifo_data, mdata);
    chk("chan",  o_fifo_chan, mchan);
    chk("cnt0",  o_drop_cnt0, mcnt0);
    chk("cnt1",  o_drop_cnt1, mcnt1);
    chk("flag",  o_drop_flag, mflag);
    chk("state", o_state,     mstate);
    if (o_fifo_push) begin
      writes++;
      if (o_fifo_chan) wr_ch1++; else wr_ch0++;
      if (first_ch < 0) first_ch = o_fifo_chan;
    end
    i_ch0_push = 0; i_ch1_push = 0; i_stat_clear = 0;
  endtask

  task automatic drive(input bit p0, input logic [DW-1:0] d0, input bit p1, input logic [DW-1:0] d1);
    i_ch0_push = p0; i_ch0_data = d0; i_ch1_push = p1; i_ch1_data = d1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_push"}, o_fifo_push, 0);
    chk({tag, "_data"}, o_fifo_data, 0);
    chk({tag, "_chan"}, o_fifo_chan, 0);
    chk({tag, "_cnt0"}, o_drop_cnt0, 0);
    chk({tag, "_cnt1"}, o_drop_cnt1, 0);
    chk({tag, "_flag"}, o_drop_flag, 0);
    chk({tag, "_state"}, o_state, 0);
  endtask

  task automatic do_reset();
    #2 i_reset_n = 0;
    #1 chk_zero_outputs("rst");
    model_reset();
    @(negedge i_clk) i_reset_n = 1;
    #1;
  endtask

  initial begin
    model_reset();
    #12 chk_zero_outputs("por");
    @(negedge i_clk) i_reset_n = 1;
    #1;

    // Single channel, in-order, 2-clock latency.
    i_mode = 2'b01; writes = 0;
    for (int k = 0; k < 4; k++) drive(1, 32'h1111_0000 + k, 0, '0);
    idle(4);
    chk("t1_writes", writes, 4);
    chk("t1_cnt0", o_drop_cnt0, 0);

    // Both channels flooding from reset: ch0 wins the first tie.
    do_reset();
    i_mode = 2'b11; writes = 0; first_ch = -1;
    for (int k = 0; k < 8; k++) drive(1, 32'hA000_0000 + k, 1, 32'hB000_0000 + k);
    idle(12);
    chk("t2_total", o_drop_cnt0 + o_drop_cnt1 + writes, 16);
    chk("t2_flag", o_drop_flag, 1);
    chk("t2_first", first_ch, 0);

    // Back-pressure: 6 pushes into a depth-4 FIFO under full.
    i_stat_clear = 1; tick();
    i_mode = 2'b01; i_fifo_full = 1; writes = 0;
    for (int k = 0; k < 6; k++) drive(1, 32'hC000_0000 + k, 0, '0);
    chk("t3_nowr", writes, 0);
    chk("t3_drop", o_drop_cnt0, 2);
    i_fifo_full = 0;
    idle(8);
    chk("t3_writes", writes, 4);

    // Mode change flushes ch1; later ch1 pushes ignored.
    i_stat_clear = 1; tick();
    i_mode = 2'b10; i_fifo_full = 1; wr_ch1 = 0;
    for (int k = 0; k < 3; k++) drive(0, '0, 1, 32'hD000_0000 + k);
    i_mode = 2'b01; i_fifo_full = 0;
    idle(3);
    for (int k = 0; k < 3; k++) drive(0, '0, 1, 32'hD100_0000 + k);
    idle(3);
    chk("t4_noch1", wr_ch1, 0);
    chk("t4_cnt1", o_drop_cnt1, 0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) i_mode = 2'($urandom_range(0, 3));
      i_fifo_full  = ($urandom_range(0, 3) == 0);
      i_stat_clear = ($urandom_range(0, 31) == 0);
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom);
    end

    // Saturation, then clear coinciding with a drop.
    i_stat_clear = 1; tick();
    i_mode = 2'b01; i_fifo_full = 1;
    for (int k = 0; k < CMAX + 8; k++) drive(1, k, 0, '0);
    chk("sat_cnt0", o_drop_cnt0, 16'hFFFF);
    i_stat_clear = 1;
    drive(1, 32'hEEEE_EEEE, 0, '0);
    chk("clr_drop_cnt0", o_drop_cnt0, 1);
    chk("clr_drop_flag", o_drop_flag, 1);

    // Async reset mid-burst, then first tie goes to ch0.
    i_fifo_full = 0; i_mode = 2'b11;
    for (int k = 0; k < 3; k++) drive(1, 32'hF000_0000 + k, 1, 32'hF100_0000 + k);
    do_reset();
    i_mode = 2'b11; first_ch = -1;
    drive(1, 32'h1234_5678, 1, 32'h8765_4321);
    idle(4);
    chk("rst_tie", first_ch, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
